rr_arb_mux_4_1: RTL and testbench
=================================

# rr_arb_mux_4_1

Round-robin arbiter and sequencer for a 4:1 data multiplexer. Four requesters each present a W-bit word with a valid/ready handshake. The block picks one requester per cycle fairly, drives the mux select, and registers the selected word into a single output stage with its own valid/ready handshake. It sits in front of a shared downstream consumer and replaces a free-running select input with a controlled, fair one.

## Interface

Parameters:
- W, default 4: data width of each input word and of y.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- d0, d1, d2, d3  in  W each  requester data words.
- req_valid  in  4  bit i: requester i offers di this cycle.
- req_ready  out  4  bit i: di accepted this cycle. Combinational, at most one bit set.
- y  out  W  registered selected word.
- sel  out  2  registered index of the requester whose word is in y.
- y_valid  out  1  y/sel hold an unconsumed word.
- y_ready  in  1  downstream accepts y this cycle.

## Operation

- State:
  - Output register: y, sel, y_valid.
  - Priority pointer ptr[1:0]: the index of the last granted requester.
- Two output states, encoded by y_valid:
  - EMPTY (y_valid=0).
  - FULL (y_valid=1).
- can_accept = !y_valid || y_ready. The register is empty, or it is being drained this cycle.
- Arbitration (combinational):
  - Search req_valid starting at (ptr+1) mod 4, then (ptr+2), (ptr+3), (ptr+4)=ptr.
  - The first set bit is the grant index g.
  - If req_valid == 0, there is no grant.
- req_ready[g] = 1 only when a grant exists and can_accept = 1. All other bits are 0.
- req_ready depends on req_valid, which is allowed. Requesters must not make req_valid depend on req_ready.
- Accept (req_valid[g] && req_ready[g]) at a clock edge:
  - y <= dg
  - sel <= g
  - y_valid <= 1
  - ptr <= g
- Drain without a new accept (y_valid && y_ready, no grant): y_valid <= 0. y and sel keep their last values.
- Stall (y_valid && !y_ready):
  - y, sel, y_valid and ptr hold.
  - req_ready = 0.
- Drain and accept in the same cycle: the new word replaces the old one and y_valid stays 1. This gives full throughput of 1 word per clock.
- ptr changes only on an accept. An idle cycle does not rotate priority.
- Fairness: a requester that holds req_valid high is accepted within at most 4 accepts.

## Timing

- Reset (rst_n=0 at a rising edge):
  - y_valid=0, y=0, sel=0, ptr=3 (so the first priority is requester 0).
  - req_ready is 0 while rst_n=0, regardless of other inputs.
- Reset asserted mid-operation:
  - Any word held in y is discarded.
  - A handshake presented in the reset cycle is not accepted.
  - Arbitration restarts from requester 0.
- Latency: an accept at edge N makes y_valid=1 with the word from cycle N visible after edge N. That is one cycle from request to output.
- With y_ready held at 1 and at least one req_valid set: one accept per cycle, no bubbles.
- While y_valid=1 and y_ready=0, y and sel are stable from cycle to cycle. This is required for downstream sampling.
- Width: y matches the selected di bit for bit, with no extension or truncation. ptr and sel wrap 3 -> 0 using modulo-4 arithmetic.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with req_valid=4'b1111 and y_ready=1.
  - During reset: req_ready=0, y_valid=0, y=0, sel=0.
  - First accept after release goes to requester 0.
- Round robin:
  - Stimulus: d0..d3 = 4'hA, 4'hB, 4'hC, 4'hD; req_valid=4'b1111; y_ready=1.
  - Required: on consecutive cycles sel=0,1,2,3,0 and y=A,B,C,D,A; y_valid stays 1.
- Skip:
  - Stimulus: req_valid=4'b1010 constant; y_ready=1.
  - Required: sel alternates 1,3,1,3; req_ready alternates 4'b0010, 4'b1000.
- Backpressure:
  - Stimulus: after requester 2 is accepted (y=C), hold y_ready=0 for 3 cycles with req_valid=4'b1111.
  - Required during the stall: y=C, sel=2, req_ready=0, ptr unchanged.
  - Required after y_ready=1: the next word comes from requester 3.
- Idle and drain:
  - Stimulus: a single accept from requester 1, then req_valid=0 with y_ready=1.
  - Required: y_valid drops after 1 cycle; y and sel hold their last values; a later req_valid=4'b0001 is granted to requester 0, because priority starts after ptr=1 and requester 0 is the only one requesting.
- Mid-operation reset:
  - Stimulus: pulse rst_n=0 for 1 cycle while y_valid=1 and ptr=2.
  - Required: y_valid=0; the next grant with req_valid=4'b1111 goes to requester 0.

Source files
------------

// File: rtl/rr_arb_mux_4_1_if.sv
// Bundle of the four requester words/handshakes and the single output stage handshake.
// valid/ready: a word moves on a rising edge where valid and ready are both 1; valid never waits on ready.
interface rr_arb_mux_4_1_if #(parameter int W = 4);
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [W-1:0] y;
  logic [1:0]   sel;
  logic         y_valid;
  logic         y_ready;

  modport master (
    output d0, d1, d2, d3, req_valid, y_ready,
    input  req_ready, y, sel, y_valid
  );

  modport slave (
    input  d0, d1, d2, d3, req_valid, y_ready,
    output req_ready, y, sel, y_valid
  );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin 4:1 arbiter feeding one registered output stage; a drain and a new
// accept may happen in the same cycle, so a steady stream runs at one word per clock.
module rr_arb_mux_4_1 #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_arb_mux_4_1_if.slave     bus,
  output logic                dbg_state,
  output logic [1:0]          dbg_ptr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic [1:0]   sel_q, sel_d;
  logic [1:0]   ptr_q, ptr_d;

  logic         can_accept;
  logic         have_grant;
  logic         accept;
  logic [1:0]   g;
  logic [1:0]   idx;
  logic [W-1:0] word;

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    have_grant = 1'b0;
    g          = 2'd0;
    idx        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!have_grant && bus.req_valid[idx]) begin
        have_grant = 1'b1;
        g          = idx;
      end
    end
  end

  always_comb begin
    word = bus.d0;
    case (g)
      2'd0: word = bus.d0;
      2'd1: word = bus.d1;
      2'd2: word = bus.d2;
      2'd3: word = bus.d3;
      default: word = bus.d0;
    endcase
  end

  assign can_accept    = (state_q == EMPTY) || bus.y_ready;
  assign accept        = rst_n && have_grant && can_accept;
  assign bus.req_ready = accept ? (4'b0001 << g) : 4'b0000;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          y_d     = word;
          sel_d   = g;
          ptr_d   = g;
        end
      end
      FULL: begin
        if (accept) begin
          y_d   = word;
          sel_d = g;
          ptr_d = g;
        end else if (bus.y_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.sel     = sel_q;
  assign bus.y_valid = (state_q == FULL);
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed bench for rr_arb_mux_4_1: reset, rotation, skip, backpressure, drain, mid-run reset.
module tb_rr_arb_mux_4_1;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  logic dbg_state;
  logic [1:0] dbg_ptr;

  rr_arb_mux_4_1_if #(.W(W)) bus ();

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", tag, act, exp);
  endtask

  // drivers: inputs change 1 time unit after the rising edge, checks follow immediately
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rv, input logic yr);
    bus.req_valid = rv;
    bus.y_ready   = yr;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] s, input logic [W-1:0] yv, input logic v);
    chk({tag, "_sel"}, 32'(bus.sel), 32'(s));
    chk({tag, "_y"}, 32'(bus.y), 32'(yv));
    chk({tag, "_valid"}, 32'(bus.y_valid), 32'(v));
  endtask

  initial begin
    logic [1:0] exp_sel;
    bus.d0 = 4'hA; bus.d1 = 4'hB; bus.d2 = 4'hC; bus.d3 = 4'hD;
    rst_n  = 1'b0;
    drive(4'b1111, 1'b1);

    // reset held two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk_out("rst", 2'd0, 4'h0, 1'b0);
    end
    chk("rst_ptr", 32'(dbg_ptr), 32'd3);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.req_ready), 32'b0001);

    // round robin: expected words queued up front
    exp_q.push_back(4'hA); exp_q.push_back(4'hB); exp_q.push_back(4'hC);
    exp_q.push_back(4'hD); exp_q.push_back(4'hA);
    exp_sel = 2'd0;
    while (exp_q.size() > 0) begin
      tick();
      chk_out("rr", exp_sel, exp_q.pop_front(), 1'b1);
      exp_sel = exp_sel + 2'd1;
    end
    chk("rr_ptr", 32'(dbg_ptr), 32'd0);

    // skip: only 1 and 3 request
    drive(4'b1010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("skip_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'b0010 : 32'b1000);
      tick();
      chk("skip_sel", 32'(bus.sel), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // backpressure: ptr=3, take 0,1,2 then stall on C
    drive(4'b1111, 1'b1);
    tick(); tick(); tick();
    chk_out("bp_load", 2'd2, 4'hC, 1'b1);
    drive(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(bus.req_ready), 32'h0);
      tick();
      chk_out("bp_stall", 2'd2, 4'hC, 1'b1);
      chk("bp_ptr", 32'(dbg_ptr), 32'd2);
    end
    drive(4'b1111, 1'b1);
    chk("bp_rel_ready", 32'(bus.req_ready), 32'b1000);
    tick();
    chk_out("bp_next", 2'd3, 4'hD, 1'b1);

    // idle and drain
    drive(4'b0010, 1'b1);
    tick();
    chk_out("idle_acc", 2'd1, 4'hB, 1'b1);
    drive(4'b0000, 1'b1);
    tick();
    chk_out("drain", 2'd1, 4'hB, 1'b0);
    tick();
    chk_out("idle_hold", 2'd1, 4'hB, 1'b0);
    chk("idle_ptr", 32'(dbg_ptr), 32'd1);
    drive(4'b0001, 1'b1);
    chk("idle_r0_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk_out("idle_r0", 2'd0, 4'hA, 1'b1);

    // mid-operation reset with a word held and ptr=2
    drive(4'b0100, 1'b1);
    tick();
    chk_out("mr_load", 2'd2, 4'hC, 1'b1);
    chk("mr_ptr", 32'(dbg_ptr), 32'd2);
    rst_n = 1'b0;
    drive(4'b1111, 1'b1);
    chk("mr_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("mr_valid", 32'(bus.y_valid), 32'd0);
    chk("mr_ptr_rst", 32'(dbg_ptr), 32'd3);
    rst_n = 1'b1;
    #1;
    chk("mr_rel_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk_out("mr_first", 2'd0, 4'hA, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
